reset_sequencer: RTL

Parametrised power-on and button reset generator with debounced push-button input and staged release of several reset domains. It drives all downstream reset domains (video timing, game logic, audio, …) from one clock. All channels are asserted together and released one at a time in index order, so earlier domains are running before later ones leave reset. It replaces the fixed 4-bit single-output pulse generator at the top level.

---
 rtl/reset_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - debounced push-button reset generator with staged multi-domain release
// Optional RESET_SEQ_HOLD_EN: hold all domains in reset while the debounced button stays pressed.
module reset_sequencer #(
  parameter int CHANNELS        = 3,
  parameter int PULSE_CYCLES    = 15,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                button_n,
  output logic [CHANNELS-1:0] rst_out,
  output logic                busy,
  output logic                done
);

  localparam int CW = (PULSE_CYCLES > 1)    ? $clog2(PULSE_CYCLES)    : 1;
  localparam int GW = (STAGE_GAP > 1)       ? $clog2(STAGE_GAP)       : 1;
  localparam int SW = (CHANNELS > 1)        ? $clog2(CHANNELS)        : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_RUN} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [GW-1:0]       r_gap;
  logic [SW-1:0]       r_stage;
  logic [CHANNELS-1:0] r_rst;
  logic                r_busy;
  logic                r_done;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_db;
  logic [DW-1:0]       r_dcnt;
  logic                r_press;
  logic                w_hold;

  // Press pulse is registered together with the falling edge of the debounced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_db    <= 1'b1;
      r_dcnt  <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= button_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_db) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_db    <= r_sync2;
        r_dcnt  <= '0;
        r_press <= r_db;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

`ifdef RESET_SEQ_HOLD_EN
  assign w_hold = ~r_db;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || r_press) begin
      r_state <= S_ASSERT;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_stage <= '0;
      r_rst   <= '1;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_ASSERT: begin
          if (w_hold) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_gap <= '0;
            if (CHANNELS == 1) begin
              r_state <= S_RUN;
              r_rst   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RELEASE;
              r_rst   <= r_rst << 1;
              r_stage <= SW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          // Zero-filled left shift keeps release monotonic: bit i never clears before bit i-1.
          if (r_gap == GW'(STAGE_GAP - 1)) begin
            r_gap <= '0;
            r_rst <= r_rst << 1;
            if (r_stage == SW'(CHANNELS - 1)) begin
              r_state <= S_RUN;
              r_stage <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_stage <= r_stage + SW'(1);
            end
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        S_RUN: begin
          r_rst <= '0;
        end
        default: begin
          r_state <= S_ASSERT;
          r_rst   <= '1;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out = r_rst;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
